// File: rtl/pipe_types_pkg.sv
// Shared pipeline-register types: control-field layout, halt bit position and
// per-stage data widths used when instantiating pipe_stage_reg.
package pipe_types_pkg;

    localparam int HALT_BIT = 0;

    // Control word carried beside the data; halt sits in bit 0.
    typedef struct packed {
        logic [5:0] opfunc;
        logic [2:0] rsvd;
        logic [1:0] MemtoReg;
        logic       RegWEN;
        logic       dWENi;
        logic       dRENi;
        logic       equal;
        logic       halt;
    } pipe_ctrl_t;

    localparam int PIPE_CTRL_W = $bits(pipe_ctrl_t);

    localparam int IFID_W = 64;   // instr, npc
    localparam int IDEX_W = 128;  // npc, portA, portB, imm
    localparam int EXMM_W = 112;  // npc, ALUOut, store, rd
    localparam int MMWB_W = 80;   // ALUOut, load, rd

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts inc_i cycles, sticks at all-ones, frozen by hold_i.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i && inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, sticky halt and a
// saturating stall counter. Define PIPE_SKID_EN to add a one-entry skid buffer.
import pipe_types_pkg::*;

module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              halted_q,    halted_d;
    logic              in_xfer, out_xfer, halt_set;

    assign out_xfer = out_valid_q & out_ready;
    assign in_xfer  = in_valid & in_ready;
    assign halt_set = out_xfer & out_ctrl_q[HALT_BIT] & ~flush;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    assign in_ready = ~halted_q & ~skid_valid_q;
`else
    assign in_ready = ~halted_q & (~out_valid_q | out_ready);
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        halted_d    = halted_q | halt_set;
`ifdef PIPE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
`endif
        // Flush and halt both empty the stage; any arriving word is dropped.
        if (flush || halted_q || halt_set) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
`ifdef PIPE_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else begin
`ifdef PIPE_SKID_EN
            if (skid_valid_q) begin
                if (out_xfer) begin
                    out_ctrl_d   = skid_ctrl_q;
                    out_data_d   = skid_data_q;
                    skid_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_ctrl_d  = in_ctrl;
                    out_data_d  = in_data;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_ctrl_d  = in_ctrl;
                    skid_data_d  = in_data;
                end
            end else if (out_xfer) begin
                out_valid_d = 1'b0;
                out_ctrl_d  = '0;
            end
`else
            if (in_xfer) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end else if (out_xfer) begin
                out_valid_d = 1'b0;
                out_ctrl_d  = '0;
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`endif

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (CLK),
        .rst_n  (nRST),
        .inc_i  (out_valid_q & ~out_ready & ~flush),
        .hold_i (halted_q),
        .cnt_o  (stall_cnt)
    );

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based model of the stage's occupancy checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 128;
    localparam int NW = 4;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, halted;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .flush(flush), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: the stage is a FIFO of up to CAP words; the output shows the head.
    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } word_t;
    word_t         q[$];
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_data;
    bit            m_halted;
    int            m_stall;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        if (m_halted) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic m_reset();
        q.delete();
        m_ctrl = '0; m_data = '0; m_halted = 1'b0; m_stall = 0;
    endtask

    task automatic step_model();
        bit pop, push, hs;
        if (!m_halted && q.size() > 0 && !out_ready && !flush && m_stall < (2**NW - 1))
            m_stall++;
        if (flush) begin
            q.delete();
            m_ctrl = '0;
        end else if (!m_halted) begin
            push = in_valid && m_in_ready();
            pop  = (q.size() > 0) && out_ready;
            hs   = pop && q[0].c[0];
            if (hs) begin
                m_halted = 1'b1;
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{c: in_ctrl, d: in_data});
            end
            if (q.size() > 0) begin
                m_ctrl = q[0].c;
                m_data = q[0].d;
            end else m_ctrl = '0;
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("in_ready",  in_ready,  m_in_ready());
            chk("out_valid", out_valid, q.size() > 0);
            chk("out_ctrl",  out_ctrl,  m_ctrl);
            chk("out_data",  out_data,  m_data);
            chk("halted",    halted,    m_halted);
            chk("stall_cnt", stall_cnt, m_stall[NW-1:0]);
        end
    end

    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
        in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = f;
        @(posedge CLK);
        step_model();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; flush = 0;
        nRST = 1'b0;
        m_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [CW-1:0] rc;
        do_reset();
        chk_en = 1'b1;
        chk("rst out_valid", out_valid, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        chk("rst in_ready",  in_ready,  1);

        // Streaming with out_ready held high: one word per cycle, 1-cycle latency.
        for (int i = 0; i < 6; i++) begin
            cyc(1, '0, 128'hA5 + 128'(i), 1, 0);
            chk("stream valid", out_valid, 1);
            chk("stream data",  out_data,  128'hA5 + 128'(i));
        end

        // Backpressure for 5 cycles.
        do_reset();
        cyc(1, '0, 128'h10, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, '0, 128'h20 + 128'(i), 0, 0);
        chk("bp data",     out_data,  128'h10);
        chk("bp stall",    stall_cnt, 5);
        chk("bp in_ready", in_ready,  0);

        // Flush with a concurrent transfer; held word has ctrl 0x3 (halt bit set).
        do_reset();
        cyc(1, 16'h3, 128'h11, 0, 0);
        cyc(1, 16'h5, 128'h22, 1, 1);
        chk("flush valid",  out_valid, 0);
        chk("flush ctrl",   out_ctrl,  0);
        chk("flush data",   out_data,  128'h11);
        chk("flush halted", halted,    0);

        // Halt word flushed before consumption.
        do_reset();
        cyc(1, 16'h1, 128'h31, 0, 0);
        cyc(0, '0, '0, 0, 1);
        cyc(1, '0, 128'h33, 1, 0);
        chk("hflush halted", halted,    0);
        chk("hflush valid",  out_valid, 1);
        chk("hflush data",   out_data,  128'h33);

        // Randomized traffic; rare halt bits, restart after each segment.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                rc = CW'($urandom) & ~CW'(1);
                if ($urandom_range(0, 31) == 0) rc[0] = 1'b1;
                cyc($urandom_range(0, 3) != 0, rc, rnd_data(),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            end
        end

        // Saturating stall, then asynchronous reset between clock edges.
        do_reset();
        cyc(1, 16'h2, 128'h77, 1, 0);
        for (int i = 0; i < 20; i++) cyc(0, '0, '0, 0, 0);
        chk("sat stall", stall_cnt, 15);
        chk("sat data",  out_data,  128'h77);
        #2;
        nRST = 1'b0;
        m_reset();
        #1;
        chk("arst valid",  out_valid, 0);
        chk("arst ctrl",   out_ctrl,  0);
        chk("arst data",   out_data,  0);
        chk("arst stall",  stall_cnt, 0);
        chk("arst halted", halted,    0);
        do_reset();

        // Halt consumed downstream: stage shuts permanently.
        cyc(1, 16'h1, 128'h44, 1, 0);
        cyc(0, '0, '0, 0, 0);
        cyc(0, '0, '0, 0, 0);
        cyc(1, '0, 128'h55, 1, 0);
        chk("halt halted", halted,    1);
        chk("halt valid",  out_valid, 0);
        for (int i = 0; i < 6; i++) cyc(1, '0, rnd_data(), $urandom_range(0, 1), 0);
        chk("halt in_ready", in_ready,  0);
        chk("halt valid2",   out_valid, 0);
        chk("halt stall",    stall_cnt, 2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
